// File: rtl/memory_address_queue_unit.sv
// Effective-address unit (base+offset) feeding a DEPTH-entry FIFO toward the load/store buffer.
// Latency: an accepted entry reaches the head one cycle later; there is no same-cycle bypass.
// Backpressure: accept drops only when the FIFO is full and the head is not leaving; flush blocks issue.
// Optional per-entry alignment flag is built when MISALIGN_CHECK_EN is defined; otherwise misaligned is tied to 0.
module memory_address_queue_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [XLEN-1:0]            base,
  input  logic [XLEN-1:0]            offset,
  input  logic [TAG_WIDTH-1:0]       tag_in,
  input  logic [1:0]                 size_in,
  input  logic                       ready_to_execute,
  output logic                       accept,
  output logic [XLEN-1:0]            result,
  output logic [TAG_WIDTH-1:0]       tag_out,
  output logic [1:0]                 size_out,
  output logic                       misaligned,
  output logic                       write_to_buffer,
  input  logic                       buffer_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [XLEN-1:0]      addr_q [DEPTH];
  logic [XLEN-1:0]      addr_d [DEPTH];
  logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
  logic [TAG_WIDTH-1:0] tag_d  [DEPTH];
  logic [1:0]           size_q [DEPTH];
  logic [1:0]           size_d [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [XLEN-1:0] eff_addr;
  logic            pop;
  logic            push;

  assign eff_addr        = base + offset;
  assign write_to_buffer = (count_q != '0);
  assign pop             = write_to_buffer & buffer_ready;
  assign accept          = ready_to_execute & ~flush & ((count_q < CNT_W'(DEPTH)) | pop);
  assign push            = accept;

  assign result   = addr_q[rd_ptr_q];
  assign tag_out  = tag_q[rd_ptr_q];
  assign size_out = size_q[rd_ptr_q];
  assign count    = count_q;

`ifdef MISALIGN_CHECK_EN
  logic mis_q [DEPTH];
  logic mis_d [DEPTH];
  logic mis_new;

  // Alignment rule per access size; the reserved encoding is always flagged.
  always_comb begin
    mis_new = 1'b0;
    case (size_in)
      2'b00:   mis_new = 1'b0;
      2'b01:   mis_new = eff_addr[0];
      2'b10:   mis_new = |eff_addr[1:0];
      default: mis_new = 1'b1;
    endcase
  end

  // Capture the flag alongside the address in the push cycle.
  always_comb begin
    mis_d = mis_q;
    if (push) mis_d[wr_ptr_q] = mis_new;
  end

  // Flag storage register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mis_q[i] <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign misaligned = mis_q[rd_ptr_q];
`else
  assign misaligned = 1'b0;
`endif

  // Write the freshly computed entry at the tail on push; storage survives flush as stale data.
  always_comb begin
    addr_d = addr_q;
    tag_d  = tag_q;
    size_d = size_q;
    if (push) begin
      addr_d[wr_ptr_q] = eff_addr;
      tag_d[wr_ptr_q]  = tag_in;
      size_d[wr_ptr_q] = size_in;
    end
  end

  // Pointer and occupancy update; flush empties the queue and wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // State registers; reset clears everything so head outputs read zero immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        tag_q[i]  <= '0;
        size_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      size_q   <= size_d;
    end
  end

endmodule

// File: tb/tb_memory_address_queue_unit.sv
// Randomized and directed bench for memory_address_queue_unit against a queue-based reference.
// Latency: the reference updates on each rising edge; DUT outputs are sampled 1 time unit after the falling edge.
// Backpressure: buffer_ready is driven randomly or per directed scenario.
module tb_memory_address_queue_unit;
  localparam int XLEN = 32;
  localparam int TW   = 5;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic [XLEN-1:0] base, offset;
  logic [TW-1:0]   tag_in;
  logic [1:0]      size_in;
  logic            ready_to_execute;
  logic            accept;
  logic [XLEN-1:0] result;
  logic [TW-1:0]   tag_out;
  logic [1:0]      size_out;
  logic            misaligned;
  logic            write_to_buffer;
  logic            buffer_ready;
  logic [2:0]      count;

  memory_address_queue_unit #(.XLEN(XLEN), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .base(base), .offset(offset),
    .tag_in(tag_in), .size_in(size_in), .ready_to_execute(ready_to_execute),
    .accept(accept), .result(result), .tag_out(tag_out), .size_out(size_out),
    .misaligned(misaligned), .write_to_buffer(write_to_buffer),
    .buffer_ready(buffer_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  t;
    logic [1:0]  s;
    logic        m;
  } ent_t;

  ent_t mq[$];
  int   total = 0;
  int   bad   = 0;
  logic last_acc;
  logic [4:0] accs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic mis_of(input logic [31:0] a, input logic [1:0] s);
`ifdef MISALIGN_CHECK_EN
    if (s == 2'd0) return 1'b0;
    if (s == 2'd1) return (a % 2) != 0;
    if (s == 2'd2) return (a % 4) != 0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One cycle: drive at negedge, check against the reference, then advance the reference at posedge.
  task automatic step(input logic rte, input logic br, input logic fl,
                      input logic [31:0] b, input logic [31:0] o,
                      input logic [4:0] t, input logic [1:0] s);
    int   n;
    logic exp_pop, exp_acc;
    ent_t e;
    @(negedge clk);
    ready_to_execute = rte; buffer_ready = br; flush = fl;
    base = b; offset = o; tag_in = t; size_in = s;
    #1;
    n = mq.size();
    exp_pop = (n > 0) && br;
    exp_acc = rte && !fl && ((n < DEPTH) || exp_pop);
    check("accept", 32'(accept), 32'(exp_acc));
    check("write_to_buffer", 32'(write_to_buffer), 32'(n > 0));
    check("count", 32'(count), 32'(n));
    if (n > 0) begin
      check("result", result, mq[0].a);
      check("tag_out", 32'(tag_out), 32'(mq[0].t));
      check("size_out", 32'(size_out), 32'(mq[0].s));
      check("misaligned", 32'(misaligned), 32'(mq[0].m));
    end
    last_acc = accept;
    e.a = b + o; e.t = t; e.s = s; e.m = mis_of(b + o, s);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (exp_pop) void'(mq.pop_front());
      if (exp_acc) mq.push_back(e);
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; base = '0; offset = '0; tag_in = '0;
    size_in = '0; ready_to_execute = 1'b0; buffer_ready = 1'b0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_wtb", 32'(write_to_buffer), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // Single op with negative offset.
    step(1, 1, 0, 32'h1000, 32'hFFFF_FFFC, 5'd7, 2'd2);
    check("t2_accept", 32'(last_acc), 32'd1);
    #2;
    check("t2_result", result, 32'h0000_0FFC);
    check("t2_tag", 32'(tag_out), 32'd7);
    check("t2_wtb", 32'(write_to_buffer), 32'd1);
    step(0, 1, 0, 0, 0, 0, 0);

    // Fill with a stalled buffer: fifth issue must be refused.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 32'h100 * (i + 1), 32'(i * 4), 5'(i + 1), 2'd2);
      accs[i] = last_acc;
    end
    check("t3_accepts", 32'(accs), 32'h0F);
    #2;
    check("t3_count", 32'(count), 32'd4);
    check("t3_head_tag", 32'(tag_out), 32'd1);

    // Full with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 32'h4000 + 32'(i * 8), 0, 5'(10 + i), 2'd1);
      check("t4_accept", 32'(last_acc), 32'd1);
    end
    #2;
    check("t4_count", 32'(count), 32'd4);

    // Flush with issue requested.
    step(0, 1, 0, 0, 0, 0, 0);
    #2;
    check("t5_count3", 32'(count), 32'd3);
    step(1, 0, 1, 32'h55, 0, 5'd3, 2'd0);
    check("t5_accept", 32'(last_acc), 32'd0);
    #2;
    check("t5_count", 32'(count), 32'd0);
    check("t5_wtb", 32'(write_to_buffer), 32'd0);

    // Alignment flag: half at odd address, then byte at same address.
    step(1, 0, 0, 32'h2001, 0, 5'd9, 2'd1);
    #2;
`ifdef MISALIGN_CHECK_EN
    check("t6_half", 32'(misaligned), 32'd1);
`else
    check("t6_half", 32'(misaligned), 32'd0);
`endif
    step(1, 1, 0, 32'h2001, 0, 5'd10, 2'd0);
    #2;
    check("t6_byte", 32'(misaligned), 32'd0);

    // Async reset with three entries queued.
    step(1, 0, 0, 32'h3000, 32'h10, 5'd11, 2'd2);
    step(1, 0, 0, 32'h3000, 32'h20, 5'd12, 2'd2);
    #2;
    check("t1_pre_count", 32'(count), 32'd3);
    @(negedge clk);
    ready_to_execute = 1'b0; buffer_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t1_count", 32'(count), 32'd0);
    check("t1_wtb", 32'(write_to_buffer), 32'd0);
    check("t1_result", result, 32'd0);
    check("t1_tag", 32'(tag_out), 32'd0);
    mq.delete();
    @(negedge clk); reset_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
           $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom,
           5'($urandom), 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
